// File: rtl/pipe_stage_skid_pkg.sv
// Shared widths and occupancy encoding for the skid-buffered pipeline stage.
package pipe_stage_skid_pkg;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_CTRL_W    = 16;
  localparam int unsigned DEF_NUM_FLUSH = 2;
  localparam int unsigned OCC_W         = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake bundle of one pipeline stage boundary.
interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned CTRL_W    = DEF_CTRL_W,
  parameter int unsigned NUM_FLUSH = DEF_NUM_FLUSH
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [CTRL_W-1:0]    in_ctrl;
  logic [DATA_W-1:0]    in_data;
  logic [NUM_FLUSH-1:0] flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [CTRL_W-1:0]    out_ctrl;
  logic [DATA_W-1:0]    out_data;
  logic [OCC_W-1:0]     occupancy;

  // Surrounding stages / environment side
  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  // Stage register side
  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_skid_entry.sv
// One buffered instruction: valid + control + data with kill/load/drop.
// Control is cleared together with valid, so an empty entry never presents live control.
module pipe_stage_skid_entry #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CTRL_W     = 16,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              kill,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLEAR_DATA) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else if (drop) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and multi-source flush.
// Head lives in the main entry; the skid entry absorbs the one extra beat of a stall.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned CTRL_W     = DEF_CTRL_W,
  parameter int unsigned NUM_FLUSH  = DEF_NUM_FLUSH,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  pipe_stage_skid_if.slave  bus
);

  occ_e                 state_q, state_d;
  logic [NUM_FLUSH-1:0] flush_vec;
  logic                 flush_any, accept, pop;
  logic                 main_valid, skid_valid;
  logic [CTRL_W-1:0]    main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0]    main_data, skid_data, main_d_data;
  logic                 main_load, main_from_skid, main_drop, skid_load, skid_drop;

  assign flush_vec = bus.flush;
  assign flush_any = |flush_vec;
  assign accept    = bus.in_valid & ~skid_valid;
  assign pop       = main_valid & bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!Reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides every transfer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !pop)      state_d = FULL;
        else if (!accept && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush_any) state_d = EMPTY;
  end

  // Entry control decode
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    unique case (state_q)
      EMPTY: main_load = accept;
      ONE: begin
        main_load = accept & pop;
        main_drop = pop & ~accept;
        skid_load = accept & ~pop;
      end
      FULL: begin
        main_load      = pop;
        main_from_skid = pop;
        skid_drop      = pop;
      end
      default: ;
    endcase
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : bus.in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : bus.in_data;

  pipe_stage_skid_entry #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)
  ) u_main (
    .clk(clk), .Reset(Reset), .kill(flush_any), .load(main_load), .drop(main_drop),
    .d_ctrl(main_d_ctrl), .d_data(main_d_data),
    .valid(main_valid), .ctrl(main_ctrl), .data(main_data)
  );

  pipe_stage_skid_entry #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)
  ) u_skid (
    .clk(clk), .Reset(Reset), .kill(flush_any), .load(skid_load), .drop(skid_drop),
    .d_ctrl(bus.in_ctrl), .d_data(bus.in_data),
    .valid(skid_valid), .ctrl(skid_ctrl), .data(skid_data)
  );

  assign bus.in_ready  = ~skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.out_ctrl  = main_ctrl;
  assign bus.out_data  = main_data;
  assign bus.occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid against a FIFO scoreboard.
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [15:0] c;
    logic [31:0] d;
  } item_t;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  bit   mon_en = 1'b0;
  int   n_err = 0;
  int   n_checks = 0;
  int   n_pop = 0;
  item_t q[$];

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(16), .NUM_FLUSH(2)) bus ();
  pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(16), .NUM_FLUSH(2)) bus_nc ();

  assign bus_nc.in_valid  = bus.in_valid;
  assign bus_nc.in_ctrl   = bus.in_ctrl;
  assign bus_nc.in_data   = bus.in_data;
  assign bus_nc.flush     = bus.flush;
  assign bus_nc.out_ready = bus.out_ready;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .NUM_FLUSH(2), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .Reset(Reset), .bus(bus)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .NUM_FLUSH(2), .CLEAR_DATA(1'b0)) dut_nc (
    .clk(clk), .Reset(Reset), .bus(bus_nc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ctrl_of(input logic [31:0] d);
    return 16'(d) ^ 16'h5A5A;
  endfunction

  task automatic drv(input logic v, input logic [31:0] d, input logic r, input logic [1:0] f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = ctrl_of(d);
    bus.out_ready = r;
    bus.flush     = f;
  endtask

  task automatic step_drv(input logic v, input logic [31:0] d, input logic r, input logic [1:0] f);
    @(posedge clk);
    #1;
    drv(v, d, r, f);
  endtask

  // Scoreboard: state checks, then pop, push and flush as seen by the coming edge
  always @(negedge clk) begin
    item_t it;
    if (!Reset) begin
      q.delete();
    end else if (mon_en) begin
      chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      if (!bus.out_valid) chk("bubble_ctrl", 64'(bus.out_ctrl), 64'(0));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("pop_unexpected", 64'(bus.out_valid), 64'(0));
        end else begin
          it = q.pop_front();
          n_pop++;
          chk("pop_data", 64'(bus.out_data), 64'(it.d));
          chk("pop_ctrl", 64'(bus.out_ctrl), 64'(it.c));
        end
      end
      if (bus.in_valid && bus.in_ready && !(|bus.flush))
        q.push_back('{c: bus.in_ctrl, d: bus.in_data});
      if (|bus.flush) q.delete();
    end
  end

  initial begin
    drv(1'b1, 32'hDEADBEEF, 1'b1, 2'b00);

    // 1: reset ignores inputs
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_occupancy", 64'(bus.occupancy), 64'(0));
    chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    @(posedge clk);
    #1;
    Reset = 1'b1;
    drv(1'b0, 32'h0, 1'b1, 2'b00);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(bus.in_ready), 64'(1));

    // 2: full-rate stream
    for (int i = 1; i <= 8; i++) begin
      step_drv(1'b1, 32'(i), 1'b1, 2'b00);
      @(negedge clk);
      if (i > 1) begin
        chk("stream_data", 64'(bus.out_data), 64'(i - 1));
        chk("stream_occ", 64'(bus.occupancy), 64'(1));
      end
    end
    step_drv(1'b0, 32'h0, 1'b1, 2'b00);
    @(negedge clk);
    chk("stream_last", 64'(bus.out_data), 64'(8));
    step_drv(1'b0, 32'h0, 1'b1, 2'b00);
    @(negedge clk);
    chk("stream_drained", 64'(bus.occupancy), 64'(0));

    // 3: stall fills the skid, release drains in order
    step_drv(1'b1, 32'hA, 1'b0, 2'b00);
    step_drv(1'b1, 32'hB, 1'b0, 2'b00);
    @(negedge clk);
    chk("stall_one_data", 64'(bus.out_data), 64'hA);
    step_drv(1'b0, 32'h0, 1'b0, 2'b00);
    @(negedge clk);
    chk("stall_full_occ", 64'(bus.occupancy), 64'(2));
    chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
    chk("stall_head", 64'(bus.out_data), 64'hA);
    step_drv(1'b0, 32'h0, 1'b0, 2'b00);
    @(negedge clk);
    chk("stall_hold", 64'(bus.out_data), 64'hA);
    step_drv(1'b0, 32'h0, 1'b1, 2'b00);
    @(negedge clk);
    chk("drain_a", 64'(bus.out_data), 64'hA);
    step_drv(1'b0, 32'h0, 1'b1, 2'b00);
    @(negedge clk);
    chk("drain_b", 64'(bus.out_data), 64'hB);
    chk("drain_b_occ", 64'(bus.occupancy), 64'(1));
    step_drv(1'b0, 32'h0, 1'b1, 2'b00);
    @(negedge clk);
    chk("drain_empty", 64'(bus.occupancy), 64'(0));

    // 4: flush while FULL with a new beat offered
    step_drv(1'b1, 32'hA, 1'b0, 2'b00);
    step_drv(1'b1, 32'hB, 1'b0, 2'b00);
    step_drv(1'b1, 32'hC, 1'b0, 2'b01);
    @(negedge clk);
    chk("flush_pre_occ", 64'(bus.occupancy), 64'(2));
    step_drv(1'b0, 32'h0, 1'b0, 2'b00);
    @(negedge clk);
    chk("flush_occ", 64'(bus.occupancy), 64'(0));
    chk("flush_valid", 64'(bus.out_valid), 64'(0));
    chk("flush_ctrl", 64'(bus.out_ctrl), 64'(0));
    chk("flush_data", 64'(bus.out_data), 64'(0));
    // flush in ONE with simultaneous accept and pop: head delivered, new beat dropped
    step_drv(1'b1, 32'h11, 1'b0, 2'b00);
    step_drv(1'b1, 32'h12, 1'b1, 2'b10);
    @(negedge clk);
    chk("flush_pop_head", 64'(bus.out_data), 64'h11);
    step_drv(1'b0, 32'h0, 1'b1, 2'b00);
    @(negedge clk);
    chk("flush_pop_empty", 64'(bus.out_valid), 64'(0));
    repeat (3) step_drv(1'b0, 32'h0, 1'b1, 2'b00);

    // 5: reset beats flush; CLEAR_DATA=0 keeps data on flush
    step_drv(1'b1, 32'h21, 1'b0, 2'b00);
    step_drv(1'b0, 32'h0, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    drv(1'b1, 32'h22, 1'b1, 2'b11);
    @(posedge clk);
    #1;
    Reset = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 2'b00);
    @(negedge clk);
    chk("rf_occ", 64'(bus.occupancy), 64'(0));
    chk("rf_valid", 64'(bus.out_valid), 64'(0));
    chk("rf_data", 64'(bus.out_data), 64'(0));
    chk("rf_ctrl", 64'(bus.out_ctrl), 64'(0));
    chk("rf_nc_data", 64'(bus_nc.out_data), 64'(0));
    step_drv(1'b1, 32'h77, 1'b0, 2'b00);
    step_drv(1'b0, 32'h0, 1'b0, 2'b01);
    @(negedge clk);
    chk("nc_pre_data", 64'(bus_nc.out_data), 64'h77);
    step_drv(1'b0, 32'h0, 1'b0, 2'b00);
    @(negedge clk);
    chk("nc_data_kept", 64'(bus_nc.out_data), 64'h77);
    chk("nc_valid", 64'(bus_nc.out_valid), 64'(0));
    chk("nc_ctrl", 64'(bus_nc.out_ctrl), 64'(0));
    chk("nc_occ", 64'(bus_nc.occupancy), 64'(0));
    chk("cd_data_zero", 64'(bus.out_data), 64'(0));

    // 6: random traffic against the scoreboard
    n_pop = 0;
    repeat (10000) begin
      step_drv(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 9) < 7),
               ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end
    step_drv(1'b0, 32'h0, 1'b1, 2'b00);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_queue", 64'(q.size()), 64'(0));
    chk("final_occ", 64'(bus.occupancy), 64'(0));
    chk("random_progress", 64'(n_pop > 2000), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
